// File: rtl/coeff_loader_if.sv
// Byte stream + coefficient memory port bundle for coeff_loader.
// master = the loader side; slave = host stream source and memory.
interface coeff_loader_if #(
  parameter int DEPTH = 24,
  parameter int WORDS = 8
);
  localparam int AW = (WORDS > 1) ? $clog2(WORDS) : 1;

  logic [7:0]       in_data;
  logic             in_valid;
  logic             in_ready;
  logic             mem_ce;
  logic             mem_we;
  logic [AW-1:0]    mem_a;
  logic [DEPTH-1:0] mem_d;
  logic [DEPTH-1:0] mem_q;

  modport master (
    input  in_data, in_valid, mem_q,
    output in_ready, mem_ce, mem_we, mem_a, mem_d
  );

  modport slave (
    output in_data, in_valid, mem_q,
    input  in_ready, mem_ce, mem_we, mem_a, mem_d
  );
endinterface

// File: rtl/coeff_loader.sv
// Coefficient memory programmer: assembles a byte stream into DEPTH-bit words,
// writes them to addresses 0..WORDS-1, then reads back and compares XOR checksums.
module coeff_loader #(
  parameter int DEPTH = 24,
  parameter int WORDS = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  coeff_loader_if.master bus,
  output logic           busy,
  output logic           done,
  output logic           err
);
  localparam int BYTES = (DEPTH + 7) / 8;
  localparam int AW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int BW    = $clog2(BYTES + 1);

  typedef enum logic [2:0] {IDLE, RECV, WRITE, VREAD, VWAIT, DONE} state_t;

  state_t           state;
  logic [AW-1:0]    addr;
  logic [BW-1:0]    byte_cnt;
  logic [DEPTH-1:0] word, wr_xor, rd_xor;
  logic             rd_vld;
  logic             in_ready, mem_ce, mem_we;
  logic [AW-1:0]    mem_a;
  logic [DEPTH-1:0] mem_d;
  logic [DEPTH+7:0] shifted;

  // New byte enters at the bottom so the first byte ends up most significant.
  assign shifted      = {word, bus.in_data};
  assign bus.in_ready = in_ready;
  assign bus.mem_ce   = mem_ce;
  assign bus.mem_we   = mem_we;
  assign bus.mem_a    = mem_a;
  assign bus.mem_d    = mem_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      addr     <= '0;
      byte_cnt <= '0;
      word     <= '0;
      wr_xor   <= '0;
      rd_xor   <= '0;
      rd_vld   <= 1'b0;
      in_ready <= 1'b0;
      mem_ce   <= 1'b0;
      mem_we   <= 1'b0;
      mem_a    <= '0;
      mem_d    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= RECV;
            addr     <= '0;
            byte_cnt <= '0;
            word     <= '0;
            wr_xor   <= '0;
            rd_xor   <= '0;
            rd_vld   <= 1'b0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
          end
        end
        RECV: begin
          if (bus.in_valid && in_ready) begin
            word <= shifted[DEPTH-1:0];
            if (byte_cnt == BW'(BYTES - 1)) begin
              // Strobe outputs are registered, so set them up on the way into WRITE.
              byte_cnt <= '0;
              in_ready <= 1'b0;
              mem_ce   <= 1'b1;
              mem_we   <= 1'b1;
              mem_a    <= addr;
              mem_d    <= shifted[DEPTH-1:0];
              state    <= WRITE;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end
        end
        WRITE: begin
          wr_xor <= wr_xor ^ mem_d;
          mem_we <= 1'b0;
          mem_d  <= '0;
          mem_a  <= '0;
          if (addr == AW'(WORDS - 1)) begin
            // mem_ce stays up: the first readback of address 0 follows directly.
            addr  <= '0;
            state <= VREAD;
          end else begin
            addr     <= addr + 1'b1;
            mem_ce   <= 1'b0;
            in_ready <= 1'b1;
            state    <= RECV;
          end
        end
        VREAD: begin
          if (rd_vld) rd_xor <= rd_xor ^ bus.mem_q;
          rd_vld <= 1'b1;
          if (addr == AW'(WORDS - 1)) begin
            mem_ce <= 1'b0;
            mem_a  <= '0;
            state  <= VWAIT;
          end else begin
            addr  <= addr + 1'b1;
            mem_a <= addr + 1'b1;
          end
        end
        VWAIT: begin
          rd_xor <= rd_xor ^ bus.mem_q;
          rd_vld <= 1'b0;
          busy   <= 1'b0;
          done   <= 1'b1;
          err    <= ((rd_xor ^ bus.mem_q) != wr_xor);
          state  <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_coeff_loader.sv
// Randomized scoreboard bench for coeff_loader with a behavioural memory model.
module tb_coeff_loader;
  localparam int DEPTH = 24;
  localparam int WORDS = 8;
  localparam int BYTES = (DEPTH + 7) / 8;
  localparam int AW    = $clog2(WORDS);

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic busy, done, err;

  always #5 clk = ~clk;

  coeff_loader_if #(.DEPTH(DEPTH), .WORDS(WORDS)) bus();

  coeff_loader #(.DEPTH(DEPTH), .WORDS(WORDS)) dut (
    .clk(clk), .reset(reset), .start(start), .bus(bus.master),
    .busy(busy), .done(done), .err(err)
  );

  typedef struct { logic [AW-1:0] a; logic [DEPTH-1:0] d; } wr_t;

  wr_t              exp_q[$];
  logic [DEPTH-1:0] mem   [WORDS];
  logic [DEPTH-1:0] words [WORDS];
  int corrupt_addr = -1;
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rd_idx = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory model: synchronous write, one-cycle read latency, optional bit-0 corruption.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.mem_ce) begin
      if (bus.mem_we) mem[bus.mem_a] <= bus.mem_d;
      else bus.mem_q <= mem[bus.mem_a] ^ ((int'(bus.mem_a) == corrupt_addr) ? DEPTH'(1) : DEPTH'(0));
    end
  end

  // Monitor: pops expected writes, tracks read addresses, checks idle port values.
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      if (bus.mem_ce && bus.mem_we) begin
        chk("in_ready_in_write", bus.in_ready, 0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got a=%0h d=%0h expected no write", bus.mem_a, bus.mem_d);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("wr_addr", bus.mem_a, e.a);
          chk("wr_data", bus.mem_d, e.d);
        end
        rd_idx = 0;
      end else if (bus.mem_ce) begin
        chk("rd_addr", bus.mem_a, rd_idx);
        chk("in_ready_in_read", bus.in_ready, 0);
        rd_idx++;
      end else begin
        chk("mem_port_idle", {bus.mem_we, bus.mem_a, bus.mem_d}, 0);
      end
      chk("busy_done_excl", busy & done, 0);
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n;
    if (gaps) repeat ($urandom_range(0, 2)) begin
      bus.in_valid = 1'b0;
      @(negedge clk);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    n = 0;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("in_ready_timeout", 0, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Byte j of a word, first byte most significant.
  function automatic logic [7:0] byte_of(input logic [DEPTH-1:0] w, input int j);
    longint v;
    v = longint'(w);
    for (int s = 0; s < BYTES - 1 - j; s++) v = v / 256;
    return 8'(v % 256);
  endfunction

  task automatic run_load(input bit gaps, input bit timed, input bit glitch, input bit exp_err);
    int t0, k;
    pulse_start();
    t0 = cyc;
    chk("done_cleared_after_start", {done, err}, 0);
    chk("in_ready_after_start", bus.in_ready, 1);
    for (int i = 0; i < WORDS; i++) begin
      exp_q.push_back('{a: AW'(i), d: words[i]});
      for (int j = 0; j < BYTES; j++) begin
        if (glitch && i == 1 && j == 1) pulse_start();
        send_byte(byte_of(words[i], j), gaps);
      end
    end
    k = 0;
    while (!done && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk("done_seen", done, 1);
    if (timed) chk("start_to_done", cyc - t0, WORDS * (BYTES + 1) + WORDS + 1);
    chk("err", err, exp_err);
    chk("busy_at_done", busy, 0);
    chk("read_count", rd_idx, WORDS);
    chk("all_writes_seen", exp_q.size(), 0);
    for (int i = 0; i < WORDS; i++) chk("mem_content", mem[i], words[i]);
  endtask

  task automatic rand_words();
    for (int i = 0; i < WORDS; i++) words[i] = DEPTH'($urandom);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {busy, done, err, bus.in_ready, bus.mem_ce, bus.mem_we, bus.mem_a, bus.mem_d}, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_outputs", {busy, done, err, bus.in_ready, bus.mem_ce}, 0);

    // Byte order: first word 0xABCDEF.
    rand_words();
    words[0] = 24'hABCDEF;
    run_load(1'b0, 1'b0, 1'b0, 1'b0);

    // Back-to-back 1..8 with start-to-done latency.
    for (int i = 0; i < WORDS; i++) words[i] = DEPTH'(i + 1);
    run_load(1'b0, 1'b1, 1'b0, 1'b0);

    // Random data with stream gaps.
    rand_words();
    run_load(1'b1, 1'b0, 1'b0, 1'b0);

    // Corrupted readback at address 3.
    corrupt_addr = 3;
    rand_words();
    run_load(1'b0, 1'b0, 1'b0, 1'b1);
    corrupt_addr = -1;

    // Restart from DONE after an error run.
    rand_words();
    run_load(1'b0, 1'b0, 1'b0, 1'b0);

    // Reset after 2 words plus 1 byte.
    rand_words();
    pulse_start();
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back('{a: AW'(i), d: words[i]});
      for (int j = 0; j < BYTES; j++) send_byte(byte_of(words[i], j), 1'b0);
    end
    send_byte(byte_of(words[2], 0), 1'b0);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_reset_outputs", {busy, done, err, bus.in_ready, bus.mem_ce, bus.mem_we, bus.mem_a, bus.mem_d}, 0);
    chk("mid_reset_writes_seen", exp_q.size(), 0);
    reset = 1'b0;
    @(negedge clk);
    rand_words();
    run_load(1'b1, 1'b0, 1'b0, 1'b0);

    // start pulsed during RECV must not restart the load.
    rand_words();
    run_load(1'b0, 1'b0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
